// File: rtl/sysbus_req_scheduler_if.sv
// Bundles the icache, dcache and Sysbus master-port handshakes of the request scheduler.
// The master modport is the scheduler's view; the slave modport is the surrounding requesters and bus.
interface sysbus_req_scheduler_if #(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 13
);
  logic [DATA_WIDTH-1:0] ireq, dreq;
  logic [TAG_WIDTH-1:0]  ireqtag, dreqtag;
  logic                  ireqcyc, dreqcyc, ireqack, dreqack;

  logic [DATA_WIDTH-1:0] iresp, dresp;
  logic [TAG_WIDTH-1:0]  iresptag, dresptag;
  logic                  irespcyc, drespcyc, irespack, drespack;

  logic [DATA_WIDTH-1:0] bus_req, bus_resp;
  logic [TAG_WIDTH-1:0]  bus_reqtag, bus_resptag;
  logic                  bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;

  modport master (
    input  ireq, ireqtag, ireqcyc, dreq, dreqtag, dreqcyc,
    output ireqack, dreqack,
    output iresp, iresptag, irespcyc, dresp, dresptag, drespcyc,
    input  irespack, drespack,
    output bus_req, bus_reqtag, bus_reqcyc,
    input  bus_reqack, bus_resp, bus_resptag, bus_respcyc,
    output bus_respack
  );

  modport slave (
    output ireq, ireqtag, ireqcyc, dreq, dreqtag, dreqcyc,
    input  ireqack, dreqack,
    input  iresp, iresptag, irespcyc, dresp, dresptag, drespcyc,
    output irespack, drespack,
    input  bus_req, bus_reqtag, bus_reqcyc,
    output bus_reqack, bus_resp, bus_resptag, bus_respcyc,
    input  bus_respack
  );
endinterface

// File: rtl/sysbus_req_scheduler.sv
// Shares one Sysbus master port between icache and dcache: one outstanding transaction,
// D priority with a starvation limit for I, response routing to the owner, WAIT timeout.
module sysbus_req_scheduler #(
  parameter int DATA_WIDTH   = 64,
  parameter int TAG_WIDTH    = 13,
  parameter int RESP_BEATS   = 8,
  parameter int NORESP_BIT   = 0,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  sysbus_req_scheduler_if.master sb,
  output logic                   owner,
  output logic                   busy,
  output logic                   timeout_err,
  output logic                   spurious_err
);
  localparam int BCW = $clog2(RESP_BEATS + 1);
  localparam int WCW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int SCW = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;

  localparam logic [BCW-1:0] LAST_BEAT  = BCW'(RESP_BEATS - 1);
  localparam logic [WCW-1:0] LAST_WAIT  = WCW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [SCW-1:0] STREAK_MAX = SCW'(MAX_D_STREAK);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] bus_req_q, bus_req_d;
  logic [TAG_WIDTH-1:0]  bus_reqtag_q, bus_reqtag_d;
  logic                  owner_q, owner_d;
  logic [SCW-1:0]        streak_q, streak_d;
  logic [BCW-1:0]        beat_cnt_q, beat_cnt_d;
  logic [WCW-1:0]        wait_cnt_q, wait_cnt_d;

  logic grant_i, grant_d, noresp, route, resp_ack, beat_ok, last_beat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      bus_req_q    <= '0;
      bus_reqtag_q <= '0;
      owner_q      <= 1'b0;
      streak_q     <= '0;
      beat_cnt_q   <= '0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      bus_req_q    <= bus_req_d;
      bus_reqtag_q <= bus_reqtag_d;
      owner_q      <= owner_d;
      streak_q     <= streak_d;
      beat_cnt_q   <= beat_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  // Beats are routed in WAIT/RESP and also in the ack cycle of a response-expecting request.
  always_comb begin
    grant_i   = sb.ireqcyc && (!sb.dreqcyc || streak_q == STREAK_MAX);
    grant_d   = !grant_i && sb.dreqcyc;
    noresp    = bus_reqtag_q[NORESP_BIT];
    route     = (state_q == WAIT) || (state_q == RESP) ||
                ((state_q == REQ) && sb.bus_reqack && !noresp);
    resp_ack  = route && (owner_q ? sb.irespack : sb.drespack);
    beat_ok   = sb.bus_respcyc && resp_ack;
    last_beat = beat_ok && (beat_cnt_q == LAST_BEAT);
  end

  always_comb begin
    state_d      = state_q;
    bus_req_d    = bus_req_q;
    bus_reqtag_d = bus_reqtag_q;
    owner_d      = owner_q;
    streak_d     = streak_q;
    beat_cnt_d   = beat_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    timeout_err  = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_i || grant_d) begin
          state_d      = REQ;
          owner_d      = grant_i;
          bus_req_d    = grant_i ? sb.ireq : sb.dreq;
          bus_reqtag_d = grant_i ? sb.ireqtag : sb.dreqtag;
          beat_cnt_d   = '0;
          // D wins while I waits: count toward the forced I grant.
          if (grant_d && sb.ireqcyc)
            streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;
          else
            streak_d = '0;
        end
      end
      REQ: begin
        if (sb.bus_reqack) begin
          if (noresp) begin
            state_d = IDLE;
          end else begin
            wait_cnt_d = '0;
            beat_cnt_d = beat_cnt_q + BCW'(beat_ok);
            if (last_beat)           state_d = IDLE;
            else if (sb.bus_respcyc) state_d = RESP;
            else                     state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + 1'b1;
        if (sb.bus_respcyc) begin
          beat_cnt_d = beat_cnt_q + BCW'(beat_ok);
          state_d    = last_beat ? IDLE : RESP;
        end else if (TIMEOUT != 0 && wait_cnt_q == LAST_WAIT) begin
          timeout_err = 1'b1;
          state_d     = IDLE;
        end
      end
      RESP: begin
        if (beat_ok) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (last_beat) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sb.bus_req     = bus_req_q;
  assign sb.bus_reqtag  = bus_reqtag_q;
  assign sb.bus_reqcyc  = (state_q == REQ);
  assign sb.ireqack     = (state_q == REQ) && owner_q && sb.bus_reqack;
  assign sb.dreqack     = (state_q == REQ) && !owner_q && sb.bus_reqack;

  // Data/tag fan-out is forced low while reset is held so every output reads 0.
  assign sb.iresp       = reset ? '0 : sb.bus_resp;
  assign sb.dresp       = reset ? '0 : sb.bus_resp;
  assign sb.iresptag    = reset ? '0 : sb.bus_resptag;
  assign sb.dresptag    = reset ? '0 : sb.bus_resptag;
  assign sb.irespcyc    = route && owner_q && sb.bus_respcyc;
  assign sb.drespcyc    = route && !owner_q && sb.bus_respcyc;
  assign sb.bus_respack = resp_ack;

  assign owner        = owner_q;
  assign busy         = (state_q != IDLE);
  assign spurious_err = !reset && sb.bus_respcyc && !route;
endmodule

// File: tb/tb_sysbus_req_scheduler.sv
// Bench for sysbus_req_scheduler: table of transactions plus hand-written sequences for
// the no-response, timeout and mid-transaction reset cases; response beats go through a scoreboard.
module tb_sysbus_req_scheduler;
  logic clk, reset;
  logic owner, busy, timeout_err, spurious_err;

  sysbus_req_scheduler_if #(.DATA_WIDTH(64), .TAG_WIDTH(13)) sb ();

  sysbus_req_scheduler #(
    .DATA_WIDTH(64), .TAG_WIDTH(13), .RESP_BEATS(8), .NORESP_BIT(0),
    .MAX_D_STREAK(4), .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset), .sb(sb),
    .owner(owner), .busy(busy), .timeout_err(timeout_err), .spurious_err(spurious_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          i_on;
    bit          d_on;
    logic [12:0] itag;
    logic [12:0] dtag;
    int          ack_dly;
    logic [7:0]  stall;
    int          abort_at;
    bit          exp_i;
  } vec_t;

  typedef struct {
    bit          is_i;
    logic [63:0] data;
    logic [12:0] tag;
  } beat_t;

  beat_t sbq[$];
  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mkdata(input logic [12:0] t);
    return 64'hC0DE_0000_0000_0000 | 64'(t);
  endfunction

  // Response monitor: every accepted beat must match the head of the scoreboard.
  always @(negedge clk) begin
    beat_t e;
    if (!reset) begin
      chk("single_dest", {63'd0, sb.irespcyc && sb.drespcyc}, 64'd0);
      if ((sb.irespcyc && sb.irespack) || (sb.drespcyc && sb.drespack)) begin
        if (sbq.size() == 0) begin
          chk("unexpected_beat", 64'd1, 64'd0);
        end else begin
          e = sbq.pop_front();
          chk("beat_dest", {63'd0, sb.irespcyc}, {63'd0, e.is_i});
          chk("beat_data", sb.irespcyc ? sb.iresp : sb.dresp, e.data);
          chk("beat_tag", 64'(sb.irespcyc ? sb.iresptag : sb.dresptag), 64'(e.tag));
        end
      end
    end
  end

  task automatic send_beats(input bit own_i, input logic [12:0] tag,
                            input logic [7:0] stall, input int abort_at);
    beat_t e;
    bit acc;
    for (int b = 0; b < 8; b++) begin
      e.is_i = own_i;
      e.data = 64'hBEEF_0000_0000_0000 | (64'(tag) << 8) | 64'(b);
      e.tag  = tag ^ 13'(b);
      sbq.push_back(e);
      sb.bus_respcyc = 1'b1;
      sb.bus_resp    = e.data;
      sb.bus_resptag = e.tag;
      sb.irespack    = own_i ? !stall[b] : 1'b1;
      sb.drespack    = own_i ? 1'b1 : !stall[b];
      if (abort_at == b + 1) begin
        #1 reset = 1'b1;
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_bus_reqcyc", {63'd0, sb.bus_reqcyc}, 64'd0);
        chk("rst_bus_req", sb.bus_req, 64'd0);
        chk("rst_bus_reqtag", 64'(sb.bus_reqtag), 64'd0);
        chk("rst_drespcyc", {63'd0, sb.drespcyc}, 64'd0);
        chk("rst_bus_respack", {63'd0, sb.bus_respack}, 64'd0);
        chk("rst_dresp", sb.dresp, 64'd0);
        chk("rst_spurious", {63'd0, spurious_err}, 64'd0);
        sbq.delete();
        @(negedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        sb.bus_respcyc = 1'b0;
        sb.irespack = 1'b1;
        sb.drespack = 1'b1;
        return;
      end
      acc = 1'b0;
      for (int n = 0; n < 4; n++) begin
        @(negedge clk);
        chk("respack_fwd", {63'd0, sb.bus_respack}, {63'd0, own_i ? sb.irespack : sb.drespack});
        chk("nonowner_respcyc", {63'd0, own_i ? sb.drespcyc : sb.irespcyc}, 64'd0);
        acc = sb.bus_respack;
        @(posedge clk); #1;
        if (acc) break;
        sb.irespack = 1'b1;
        sb.drespack = 1'b1;
      end
      if (!acc) chk("beat_accept_timeout", 64'd0, 64'd1);
    end
    sb.bus_respcyc = 1'b0;
  endtask

  // Entered at posedge+1 with the DUT idle; returns at posedge+1 of the next idle cycle.
  task automatic run_txn(input vec_t v);
    int n;
    logic [12:0] tag;
    sb.ireqcyc = v.i_on; sb.ireqtag = v.itag; sb.ireq = mkdata(v.itag);
    sb.dreqcyc = v.d_on; sb.dreqtag = v.dtag; sb.dreq = mkdata(v.dtag);
    tag = v.exp_i ? v.itag : v.dtag;
    @(negedge clk);
    chk("idle_before_grant", {63'd0, busy}, 64'd0);
    n = 0;
    while (!sb.bus_reqcyc && n < 16) begin
      @(negedge clk);
      n++;
    end
    chk("grant_latency", 64'(n), 64'd1);
    chk("grant_owner", {63'd0, owner}, {63'd0, v.exp_i});
    chk("bus_reqtag", 64'(sb.bus_reqtag), 64'(tag));
    chk("bus_req", sb.bus_req, mkdata(tag));
    if (v.ack_dly == 0) #1;
    else repeat (v.ack_dly) @(posedge clk);
    #1 sb.bus_reqack = 1'b1;
    #1;
    chk("owner_reqack", {63'd0, v.exp_i ? sb.ireqack : sb.dreqack}, 64'd1);
    chk("other_reqack", {63'd0, v.exp_i ? sb.dreqack : sb.ireqack}, 64'd0);
    @(posedge clk); #1;
    sb.bus_reqack = 1'b0;
    if (v.exp_i) sb.ireqcyc = 1'b0; else sb.dreqcyc = 1'b0;
    send_beats(v.exp_i, tag, v.stall, v.abort_at);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[10];
    int n;
    tbl[0] = '{0, 1, 13'h000, 13'h010, 2, 8'h00, 0, 0};          // single D transaction
    tbl[1] = '{1, 1, 13'h102, 13'h020, 0, 8'h00, 0, 0};          // both pending: D,D,D,D,I,D
    tbl[2] = '{1, 1, 13'h102, 13'h022, 1, 8'h00, 0, 0};
    tbl[3] = '{1, 1, 13'h102, 13'h024, 0, 8'h00, 0, 0};
    tbl[4] = '{1, 1, 13'h102, 13'h026, 1, 8'h00, 0, 0};
    tbl[5] = '{1, 1, 13'h102, 13'h028, 0, 8'h00, 0, 1};
    tbl[6] = '{1, 1, 13'h104, 13'h028, 0, 8'h00, 0, 0};
    tbl[7] = '{1, 0, 13'h0A4, 13'h000, 1, 8'b0000_0110, 0, 1}; // I owner stalls beats 2-3
    tbl[8] = '{0, 1, 13'h000, 13'h050, 1, 8'h00, 3, 0};        // reset during beat 3
    tbl[9] = '{0, 1, 13'h000, 13'h052, 0, 8'h01, 0, 0};        // clean D after reset

    reset = 1'b1;
    sb.ireq = '0; sb.ireqtag = '0; sb.ireqcyc = 1'b0;
    sb.dreq = '0; sb.dreqtag = '0; sb.dreqcyc = 1'b0;
    sb.irespack = 1'b1; sb.drespack = 1'b1;
    sb.bus_reqack = 1'b0; sb.bus_resp = '0; sb.bus_resptag = '0; sb.bus_respcyc = 1'b0;
    #3;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_reqcyc", {63'd0, sb.bus_reqcyc}, 64'd0);
    chk("reset_bus_req", sb.bus_req, 64'd0);
    chk("reset_owner", {63'd0, owner}, 64'd0);
    #19 reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) run_txn(tbl[i]);

    // No-response request: back to IDLE right after the ack, later beats are spurious.
    sb.dreqcyc = 1'b1; sb.dreqtag = 13'h031; sb.dreq = mkdata(13'h031);
    @(negedge clk);
    @(negedge clk);
    chk("noresp_reqcyc", {63'd0, sb.bus_reqcyc}, 64'd1);
    chk("noresp_reqtag", 64'(sb.bus_reqtag), 64'h031);
    @(posedge clk); #1 sb.bus_reqack = 1'b1;
    @(negedge clk);
    chk("noresp_dreqack", {63'd0, sb.dreqack}, 64'd1);
    @(posedge clk); #1 sb.bus_reqack = 1'b0; sb.dreqcyc = 1'b0;
    @(negedge clk);
    chk("noresp_idle", {63'd0, busy}, 64'd0);
    @(posedge clk); #1 sb.bus_respcyc = 1'b1;
    @(negedge clk);
    chk("spurious_pulse", {63'd0, spurious_err}, 64'd1);
    chk("spurious_respack", {63'd0, sb.bus_respack}, 64'd0);
    chk("spurious_drespcyc", {63'd0, sb.drespcyc}, 64'd0);
    @(posedge clk); #1 sb.bus_respcyc = 1'b0;
    @(negedge clk);
    chk("spurious_clear", {63'd0, spurious_err}, 64'd0);

    // Hung D transaction times out; the I request raised meanwhile is granted next.
    @(posedge clk); #1;
    sb.dreqcyc = 1'b1; sb.dreqtag = 13'h040; sb.dreq = mkdata(13'h040);
    @(negedge clk);
    @(negedge clk);
    chk("to_reqcyc", {63'd0, sb.bus_reqcyc}, 64'd1);
    @(posedge clk); #1 sb.bus_reqack = 1'b1;
    @(posedge clk); #1 sb.bus_reqack = 1'b0; sb.dreqcyc = 1'b0;
    sb.ireqcyc = 1'b1; sb.ireqtag = 13'h0C1; sb.ireq = mkdata(13'h0C1);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (timeout_err) break;
    end
    chk("timeout_cycles", 64'(n), 64'd16);
    @(negedge clk);
    chk("timeout_idle", {63'd0, busy}, 64'd0);
    @(negedge clk);
    chk("after_to_reqcyc", {63'd0, sb.bus_reqcyc}, 64'd1);
    chk("after_to_owner", {63'd0, owner}, 64'd1);
    chk("after_to_reqtag", 64'(sb.bus_reqtag), 64'h0C1);
    @(posedge clk); #1 sb.bus_reqack = 1'b1;
    @(negedge clk);
    chk("after_to_ireqack", {63'd0, sb.ireqack}, 64'd1);
    @(posedge clk); #1 sb.bus_reqack = 1'b0; sb.ireqcyc = 1'b0;
    @(negedge clk);
    chk("after_to_idle", {63'd0, busy}, 64'd0);

    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
